multicycle_controller: RTL

//  Moore FSM that sequences the shared-memory, single-ALU multicycle MIPS datapath.

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/mc_aludec.sv | 24 ++
 rtl/multicycle_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path:
// opcodes, functs, ALU control codes, FSM states and mux selects.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ANDIEX = 4'd10,
        S_ORIEX  = 4'd11,
        S_IMMWB  = 4'd12,
        S_JUMP   = 4'd13
    } state_t;

endpackage

// File: rtl/mc_aludec.sv
// R-type funct decoder: ALU control code plus a flag saying
// whether the funct is one the datapath supports.
module mc_aludec
    import mips_pkg::*;
(
    input  logic [5:0] Funct,
    output logic [2:0] AluCtl,
    output logic       Valid
);

    always_comb begin
        AluCtl = ALU_ADD;
        Valid  = 1'b1;
        unique case (Funct)
            FUNCT_ADD: AluCtl = ALU_ADD;
            FUNCT_SUB: AluCtl = ALU_SUB;
            FUNCT_AND: AluCtl = ALU_AND;
            FUNCT_OR:  AluCtl = ALU_OR;
            FUNCT_SLT: AluCtl = ALU_SLT;
            default:   Valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore controller for the shared-memory multicycle MIPS datapath:
// state register, next-state logic and per-state output decode.
module multicycle_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [2:0] AluCtl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       ExtOp,
    output logic       IllegalOp
);

    state_t     state;
    state_t     stateNext;
    logic [2:0] functCtl;
    logic       functValid;
    logic       pcWrite;
    logic       branch;
    logic       memWriteRaw;
    logic       irWriteRaw;
    logic       regWriteRaw;
    logic       isLogicImm;

    mc_aludec uAluDec (
        .Funct  (Funct),
        .AluCtl (functCtl),
        .Valid  (functValid)
    );

    assign isLogicImm = (Op == OP_ANDI) || (Op == OP_ORI);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext   = S_FETCH;
        IorD        = 1'b0;
        memWriteRaw = 1'b0;
        irWriteRaw  = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        regWriteRaw = 1'b0;
        AluSrcA     = 1'b0;
        AluSrcB     = SRCB_RT;
        AluCtl      = ALU_AND;
        PCSrc       = PC_ALU;
        pcWrite     = 1'b0;
        branch      = 1'b0;
        ExtOp       = 1'b1;
        IllegalOp   = 1'b0;
        unique case (state)
            S_FETCH: begin
                irWriteRaw = 1'b1;
                AluSrcB    = SRCB_FOUR;
                AluCtl     = ALU_ADD;
                pcWrite    = 1'b1;
                stateNext  = S_DECODE;
            end
            S_DECODE: begin
                AluSrcB = SRCB_IMMSH;
                AluCtl  = ALU_ADD;
                unique case (Op)
                    OP_LW, OP_SW:   stateNext = S_MEMADR;
                    OP_BEQ, OP_BNE: stateNext = S_BRANCH;
                    OP_ADDI:        stateNext = S_ADDIEX;
                    OP_ANDI:        stateNext = S_ANDIEX;
                    OP_ORI:         stateNext = S_ORIEX;
                    OP_J:           stateNext = S_JUMP;
                    OP_RTYPE: begin
                        stateNext = functValid ? S_EXEC : S_FETCH;
                        IllegalOp = !functValid;
                    end
                    default: IllegalOp = 1'b1;
                endcase
            end
            S_MEMADR: begin
                AluSrcA   = 1'b1;
                AluSrcB   = SRCB_IMM;
                AluCtl    = ALU_ADD;
                stateNext = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD      = 1'b1;
                stateNext = S_MEMWB;
            end
            S_MEMWB: begin
                MemToReg    = 1'b1;
                regWriteRaw = 1'b1;
            end
            S_MEMWR: begin
                IorD        = 1'b1;
                memWriteRaw = 1'b1;
            end
            S_EXEC: begin
                AluSrcA   = 1'b1;
                AluCtl    = functCtl;
                stateNext = S_ALUWB;
            end
            S_ALUWB: begin
                // Keep the ALU op steady while ALUOut is written back
                AluCtl      = functCtl;
                RegDst      = 1'b1;
                regWriteRaw = 1'b1;
            end
            S_BRANCH: begin
                AluSrcA = 1'b1;
                AluCtl  = ALU_SUB;
                PCSrc   = PC_ALUOUT;
                branch  = 1'b1;
            end
            S_ADDIEX, S_ANDIEX, S_ORIEX: begin
                AluSrcA   = 1'b1;
                AluSrcB   = SRCB_IMM;
                stateNext = S_IMMWB;
                unique case (state)
                    S_ANDIEX: begin
                        AluCtl = ALU_AND;
                        ExtOp  = 1'b0;
                    end
                    S_ORIEX: begin
                        AluCtl = ALU_OR;
                        ExtOp  = 1'b0;
                    end
                    default: AluCtl = ALU_ADD;
                endcase
            end
            S_IMMWB: begin
                regWriteRaw = 1'b1;
                ExtOp       = !isLogicImm;
            end
            S_JUMP: begin
                PCSrc   = PC_JUMP;
                pcWrite = 1'b1;
            end
            default: stateNext = S_FETCH;
        endcase
    end

    // Strobes are killed while reset is held so an abandoned op writes nothing
    assign MemWrite = memWriteRaw && !reset;
    assign IRWrite  = irWriteRaw && !reset;
    assign RegWrite = regWriteRaw && !reset;
    assign PCEn     = !reset &&
                      (pcWrite || (branch && ((Op == OP_BNE) ^ Zero)));

endmodule
